// File: rtl/vga_tile_ram_arbiter.sv
// Purpose : shares one single-port tile RAM between the display fetch path and a CPU port.
// Latency : display tile code is registered once per 8-pixel group; CPU write ack 1 cycle
//           after grant, CPU read ack 3 cycles after grant.
// Backpressure: the display slot always wins the RAM; a CPU request colliding with a slot
//           is granted one cycle later and is held by the requester until o_Cpu_Ack.
//
// Ports:
//   i_Clk, i_Reset                 pixel clock, asynchronous active-high reset
//   i_Col_Count, i_Row_Count       raster position from the sync generator
//   o_Tile_Data, o_Tile_Valid      tile code for the current 8-pixel group
//   i_Cpu_Req/We/Addr/Wr_Data      CPU request, held stable until acked
//   o_Cpu_Ack, o_Cpu_Rd_Data       one-cycle completion pulse, read data in that cycle
//   o_Ram_Addr/We/Wr_Data          registered RAM controls
//   i_Ram_Rd_Data                  RAM read data, one cycle after o_Ram_Addr
module vga_tile_ram_arbiter #(
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int DATA_W      = 4,
  parameter int ADDR_W      = 13
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [9:0]        i_Col_Count,
  input  logic [9:0]        i_Row_Count,
  output logic [DATA_W-1:0] o_Tile_Data,
  output logic              o_Tile_Valid,
  input  logic              i_Cpu_Req,
  input  logic              i_Cpu_We,
  input  logic [ADDR_W-1:0] i_Cpu_Addr,
  input  logic [DATA_W-1:0] i_Cpu_Wr_Data,
  output logic              o_Cpu_Ack,
  output logic [DATA_W-1:0] o_Cpu_Rd_Data,
  output logic [ADDR_W-1:0] o_Ram_Addr,
  output logic              o_Ram_We,
  output logic [DATA_W-1:0] o_Ram_Wr_Data,
  input  logic [DATA_W-1:0] i_Ram_Rd_Data
);

  localparam int TPR  = ACTIVE_COLS / 8;
  localparam int NT   = TPR * (ACTIVE_ROWS / 8);
  localparam int AW1  = ADDR_W + 1;

  localparam logic [9:0]    LAST_GRP_COL = 10'(TOTAL_COLS - 8);
  localparam logic [9:0]    LAST_COL     = 10'(TOTAL_COLS - 1);
  localparam logic [9:0]    LAST_ROW     = 10'(TOTAL_ROWS - 1);
  localparam logic [10:0]   ACT_COLS_W   = 11'(ACTIVE_COLS);
  localparam logic [9:0]    ACT_ROWS_W   = 10'(ACTIVE_ROWS);
  localparam logic [9:0]    TPR_W        = 10'(TPR);
  localparam logic [AW1-1:0] NT_W        = AW1'(NT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_ADDR,
    S_RD_WAIT,
    S_RD_ACK
  } state_t;

  state_t state, state_next;

  // ---------------------------------------------------------------
  // Display slot decode (combinational on the sampled counters)
  // ---------------------------------------------------------------
  logic              last_grp;
  logic [9:0]        next_row;
  logic [9:0]        tgt_row;
  logic [9:0]        tgt_grp;
  logic              slot;
  logic [ADDR_W-1:0] disp_addr;
  logic              valid_next;

  always_comb begin
    last_grp  = (i_Col_Count == LAST_GRP_COL);
    next_row  = (i_Row_Count == LAST_ROW) ? 10'd0 : i_Row_Count + 10'd1;
    // The last slot of a line prefetches group 0 of the following line.
    tgt_row   = last_grp ? next_row : i_Row_Count;
    tgt_grp   = last_grp ? 10'd0 : {3'b000, i_Col_Count[9:3]} + 10'd1;
    slot      = (i_Col_Count[2:0] == 3'd0) && (tgt_grp < TPR_W) && (tgt_row < ACT_ROWS_W);
    disp_addr = ADDR_W'(tgt_row[9:3]) * ADDR_W'(TPR) + ADDR_W'(tgt_grp);
    // Validity describes the column that follows the current one.
    valid_next = (({1'b0, i_Col_Count} + 11'd1 < ACT_COLS_W) && (i_Row_Count < ACT_ROWS_W)) ||
                 ((i_Col_Count == LAST_COL) && (next_row < ACT_ROWS_W));
  end

  // ---------------------------------------------------------------
  // CPU FSM and RAM control next-state
  // ---------------------------------------------------------------
  logic              cpu_in_range;
  logic              cpu_oob;
  logic              oob_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic              ram_we_d;
  logic [DATA_W-1:0] ram_wr_d;
  logic              ack_d;
  logic [DATA_W-1:0] rd_data_d;

  assign cpu_in_range = ({1'b0, i_Cpu_Addr} < NT_W);

  always_comb begin
    state_next = state;
    ram_addr_d = '0;
    ram_we_d   = 1'b0;
    ram_wr_d   = '0;
    ack_d      = 1'b0;
    rd_data_d  = o_Cpu_Rd_Data;
    oob_d      = cpu_oob;

    if (slot) begin
      ram_addr_d = disp_addr;
    end

    case (state)
      S_IDLE: begin
        if (i_Cpu_Req && !slot) begin
          ram_addr_d = i_Cpu_Addr;
          oob_d      = !cpu_in_range;
          if (i_Cpu_We) begin
            // Out-of-range writes are dropped at the RAM but still acknowledged.
            ram_we_d   = cpu_in_range;
            ram_wr_d   = i_Cpu_Wr_Data;
            ack_d      = 1'b1;
            state_next = S_WR;
          end else begin
            state_next = S_RD_ADDR;
          end
        end
      end
      S_WR:      state_next = S_IDLE;
      S_RD_ADDR: state_next = S_RD_WAIT;
      S_RD_WAIT: begin
        rd_data_d  = cpu_oob ? '0 : i_Ram_Rd_Data;
        ack_d      = 1'b1;
        state_next = S_RD_ACK;
      end
      S_RD_ACK:  state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state         <= S_IDLE;
      cpu_oob       <= 1'b0;
      o_Ram_Addr    <= '0;
      o_Ram_We      <= 1'b0;
      o_Ram_Wr_Data <= '0;
      o_Cpu_Ack     <= 1'b0;
      o_Cpu_Rd_Data <= '0;
    end else begin
      state         <= state_next;
      cpu_oob       <= oob_d;
      o_Ram_Addr    <= ram_addr_d;
      o_Ram_We      <= ram_we_d;
      o_Ram_Wr_Data <= ram_wr_d;
      o_Cpu_Ack     <= ack_d;
      o_Cpu_Rd_Data <= rd_data_d;
    end
  end

  // ---------------------------------------------------------------
  // Display data pipeline: slot -> RAM addr -> RAM data -> hold -> output
  // ---------------------------------------------------------------
  logic              disp_p1;
  logic              disp_p2;
  logic [DATA_W-1:0] hold;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      disp_p1      <= 1'b0;
      disp_p2      <= 1'b0;
      hold         <= '0;
      o_Tile_Data  <= '0;
      o_Tile_Valid <= 1'b0;
    end else begin
      disp_p1 <= slot;
      disp_p2 <= disp_p1;
      if (disp_p2) begin
        hold <= i_Ram_Rd_Data;
      end
      // Update on the last column of a group so the code covers the next 8 columns.
      if (i_Col_Count[2:0] == 3'd7) begin
        o_Tile_Valid <= valid_next;
        o_Tile_Data  <= valid_next ? hold : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_tile_ram_arbiter.sv
module tb_vga_tile_ram_arbiter;

  localparam int TC  = 800;
  localparam int TR  = 28;
  localparam int AC  = 640;
  localparam int AR  = 24;
  localparam int DW  = 4;
  localparam int AW  = 13;
  localparam int TPR = AC / 8;
  localparam int NT  = TPR * (AR / 8);

  logic          clk = 1'b0;
  logic          rst;
  int            col, row;
  logic [DW-1:0] tile_data;
  logic          tile_valid;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wd;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rd;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wr;
  logic [DW-1:0] ram_q;

  always #5 clk = ~clk;

  vga_tile_ram_arbiter #(
    .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .DATA_W(DW), .ADDR_W(AW)
  ) dut (
    .i_Clk(clk),
    .i_Reset(rst),
    .i_Col_Count(col[9:0]),
    .i_Row_Count(row[9:0]),
    .o_Tile_Data(tile_data),
    .o_Tile_Valid(tile_valid),
    .i_Cpu_Req(cpu_req),
    .i_Cpu_We(cpu_we),
    .i_Cpu_Addr(cpu_addr),
    .i_Cpu_Wr_Data(cpu_wd),
    .o_Cpu_Ack(cpu_ack),
    .o_Cpu_Rd_Data(cpu_rd),
    .o_Ram_Addr(ram_addr),
    .o_Ram_We(ram_we),
    .o_Ram_Wr_Data(ram_wr),
    .i_Ram_Rd_Data(ram_q)
  );

  // Synchronous single-port tile RAM; unwritten locations read as index mod 16.
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  bit            written [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr]     <= ram_wr;
      written[ram_addr] <= 1'b1;
    end
    ram_q <= written[ram_addr] ? mem[ram_addr] : ram_addr[3:0];
  end

  // Expected RAM contents as seen by the display.
  logic [DW-1:0] model [0:(1<<AW)-1];

  typedef struct {
    int            cyc;
    logic          rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_ack_cyc = -10;
  logic disp_chk = 1'b0;
  logic ack_seen = 1'b0;
  logic watch_we = 1'b0;
  logic we_seen  = 1'b0;

  function automatic logic slot_at(input int c, input int r);
    int g, t;
    if ((c % 8) != 0) return 1'b0;
    if (c == TC - 8) begin
      g = 0;
      t = (r == TR - 1) ? 0 : r + 1;
    end else begin
      g = c / 8 + 1;
      t = r;
    end
    return (g < TPR) && (t < AR);
  endfunction

  task automatic check_cycle();
    logic          act;
    logic [DW-1:0] expd;
    exp_t          e;
    if (disp_chk) begin
      act  = (col < AC) && (row < AR);
      expd = act ? model[(row / 8) * TPR + col / 8] : 4'd0;
      total++;
      assert ({tile_valid, tile_data} === {act, expd}) else begin
        bad++;
        $error("FAIL tile row=%0d col=%0d got v=%0b d=%0h exp v=%0b d=%0h",
               row, col, tile_valid, tile_data, act, expd);
      end
    end
    if (watch_we && ram_we) we_seen = 1'b1;
    if (cpu_ack === 1'b1) begin
      ack_seen = 1'b1;
      total++;
      assert (last_ack_cyc != cyc - 1) else begin
        bad++;
        $error("FAIL ack_back_to_back cyc=%0d prev=%0d exp gap>1", cyc, last_ack_cyc);
      end
      last_ack_cyc = cyc;
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_ack cyc=%0d got ack=1 exp ack=0", cyc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        assert (cyc === e.cyc) else begin
          bad++;
          $error("FAIL ack_cycle got=%0d exp=%0d", cyc, e.cyc);
        end
        if (e.rd) begin
          total++;
          assert (cpu_rd === e.data) else begin
            bad++;
            $error("FAIL rd_data got=%0h exp=%0h", cpu_rd, e.data);
          end
        end
      end
    end
  endtask

  // Check the current cycle, then advance to the next pixel.
  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    cyc++;
    #1;
    if (col == TC - 1) begin
      col = 0;
      row = (row == TR - 1) ? 0 : row + 1;
    end else begin
      col = col + 1;
    end
  endtask

  task automatic run_to(input int r, input int c, input int max_cyc, input string tag);
    int k;
    k = 0;
    while (!(row == r && col == c) && k < max_cyc) begin
      step();
      k++;
    end
    total++;
    assert (row == r && col == c) else begin
      bad++;
      $error("FAIL %s got row=%0d col=%0d exp row=%0d col=%0d", tag, row, col, r, c);
    end
  endtask

  task automatic cpu_op(input logic we, input int addr, input logic [DW-1:0] wd, input logic keep_req);
    exp_t e;
    int   lat;
    lat = (slot_at(col, row) ? 1 : 0) + (we ? 1 : 3);
    cpu_req  = 1'b1;
    cpu_we   = we;
    cpu_addr = AW'(addr);
    cpu_wd   = wd;
    e.cyc  = cyc + lat;
    e.rd   = !we;
    e.data = (addr < NT) ? model[addr] : 4'd0;
    sb.push_back(e);
    if (we && addr < NT) model[addr] = wd;
    ack_seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (ack_seen) break;
    end
    total++;
    assert (ack_seen) else begin
      bad++;
      $error("FAIL ack_timeout addr=%0d got ack=0 exp ack=1", addr);
    end
    if (!keep_req) cpu_req = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    cpu_req  = 1'b0;
    cpu_we   = 1'b0;
    cpu_addr = '0;
    cpu_wd   = '0;
    col      = 0;
    row      = AR;
    for (int i = 0; i < (1 << AW); i++) model[i] = 4'(i);

    #2;
    total++;
    assert ({tile_data, tile_valid, cpu_ack, cpu_rd, ram_addr, ram_we, ram_wr} === 28'd0) else begin
      bad++;
      $error("FAIL reset_state got=%0h exp=0",
             {tile_data, tile_valid, cpu_ack, cpu_rd, ram_addr, ram_we, ram_wr});
    end
    step();
    step();
    rst = 1'b0;
    step();

    // Read aborted by reset while waiting for RAM data.
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 13'd5;
    step();
    total++;
    assert (ram_addr === 13'd5 && ram_we === 1'b0) else begin
      bad++;
      $error("FAIL rd_addr_issue got addr=%0d we=%0b exp addr=5 we=0", ram_addr, ram_we);
    end
    step();
    rst = 1'b1;
    #1;
    total++;
    assert ({tile_data, tile_valid, cpu_ack, cpu_rd, ram_addr, ram_we, ram_wr} === 28'd0) else begin
      bad++;
      $error("FAIL mid_read_reset got=%0h exp=0",
             {tile_data, tile_valid, cpu_ack, cpu_rd, ram_addr, ram_we, ram_wr});
    end
    cpu_req = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    cpu_op(1'b0, 5, 4'h0, 1'b0);

    // Prime the display pipeline, then check a whole frame.
    col = 0;
    row = TR - 2;
    run_to(0, 0, 2 * TC + 10, "reach_frame1");
    disp_chk = 1'b1;
    run_to(AR, 0, TC * AR + 10, "reach_vblank1");

    // Vertical blanking: every RAM cycle belongs to the CPU.
    cpu_op(1'b1, 81, 4'hA, 1'b0);
    cpu_op(1'b0, 81, 4'h0, 1'b0);
    cpu_op(1'b0, 7, 4'h0, 1'b0);
    watch_we = 1'b1;
    we_seen  = 1'b0;
    cpu_op(1'b1, NT, 4'h5, 1'b0);
    step();
    watch_we = 1'b0;
    total++;
    assert (we_seen === 1'b0 && written[NT] == 1'b0) else begin
      bad++;
      $error("FAIL oob_write got we_seen=%0b written=%0b exp 0 0", we_seen, written[NT]);
    end
    cpu_op(1'b0, NT, 4'h0, 1'b0);
    cpu_op(1'b0, 5000, 4'h0, 1'b0);

    // Frame 2: read colliding with a display slot, then back-to-back writes.
    run_to(0, 0, TC * (TR - AR) + 10, "reach_frame2");
    run_to(0, 16, 20, "reach_col16");
    cpu_op(1'b0, 81, 4'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cpu_op(1'b1, 2 * TPR + i, 4'((i * 5 + 3) % 16), 1'b1);
    end
    cpu_op(1'b0, 2 * TPR, 4'h0, 1'b1);
    cpu_op(1'b0, 2 * TPR + 7, 4'h0, 1'b0);
    run_to(AR, 0, TC * AR + 10, "reach_vblank2");
    repeat (4) step();

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_drained got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
